// File: rtl/airi5c_lnormalizer.sv
// ---------------------------------------------------------------------------
// airi5c_lnormalizer
//
// Sequential left normalizer for the FPU datapath. Shifts a mantissa left
// until its MSB is set, but never further than a caller-supplied limit (the
// denormal exponent floor) or n. It reports the applied shift amount.
// One power-of-two stage is applied per clock, largest stage first. The
// greedy MSB-first order yields exactly min(lzc(in), limit, n).
//
// Optional feature macro: AIRI5C_LNORM_EARLY_EXIT_EN
//   When defined, a BUSY cycle finishes immediately if the value is already
//   normalized or the shift count has reached its cap. Latency is then
//   1..s cycles. When undefined, latency is a fixed s cycles.
//
// Ports
//   clk      in   1   rising-edge clock
//   n_reset  in   1   asynchronous active-low reset
//   kill     in   1   abort, return to IDLE, clear results (wins over load)
//   load     in   1   start; captures in and limit
//   in       in   n   value to normalize
//   limit    in   s   maximum permitted left shift
//   out      out  n   normalized value
//   shamt    out  s   applied left shift
//   zero     out  1   captured in was all zeros
//   ready    out  1   result valid level, held until next load/kill
// ---------------------------------------------------------------------------
module airi5c_lnormalizer #(
  parameter int n = 24,
  parameter int s = 5
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         kill,
  input  logic         load,
  input  logic [n-1:0] in,
  input  logic [s-1:0] limit,
  output logic [n-1:0] out,
  output logic [s-1:0] shamt,
  output logic         zero,
  output logic         ready
);

  localparam int SW = (s > 1) ? $clog2(s) : 1;
  localparam logic [s:0]    N_EXT     = (s+1)'(n);
  localparam logic [s:0]    ONE_EXT   = (s+1)'(1);
  localparam logic [SW-1:0] STAGE_TOP = SW'(s-1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e        state_q, state_d;
  logic [n-1:0]  val_q, val_d;
  logic [s-1:0]  cnt_q, cnt_d;
  logic [s-1:0]  lim_q, lim_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [n-1:0]  out_q, out_d;
  logic [s-1:0]  shamt_q, shamt_d;
  logic          zero_q, zero_d;
  logic          ready_q, ready_d;

  // Stage datapath, all at s+1 bits so cnt+step cannot wrap.
  logic [s:0]   step;      // 2**stage
  logic [s:0]   take;      // min(2**stage, n): bits that must be zero to shift
  logic [s:0]   cap;       // min(lim, n)
  logic [s:0]   cnt_sum;
  logic         top_zero;
  logic         do_shift;
  logic [n-1:0] val_sh;
  logic [n-1:0] val_nx;
  logic [s-1:0] cnt_nx;

  always_comb begin
    step     = ONE_EXT << stage_q;
    take     = (step > N_EXT) ? N_EXT : step;
    cap      = ({1'b0, lim_q} > N_EXT) ? N_EXT : {1'b0, lim_q};
    cnt_sum  = {1'b0, cnt_q} + step;
    top_zero = ((val_q >> (N_EXT - take)) == '0);
    do_shift = top_zero && (cnt_sum <= cap);
    val_sh   = val_q << step;
    val_nx   = do_shift ? val_sh : val_q;
    cnt_nx   = do_shift ? cnt_sum[s-1:0] : cnt_q;
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    stage_d = stage_q;
    out_d   = out_q;
    shamt_d = shamt_q;
    zero_d  = zero_q;
    ready_d = ready_q;

    if (kill) begin
      state_d = IDLE;
      ready_d = 1'b0;
      out_d   = '0;
      shamt_d = '0;
      zero_d  = 1'b0;
    end else if (load) begin
      // Restarts from any state; a result in flight is simply dropped.
      state_d = BUSY;
      val_d   = in;
      cnt_d   = '0;
      lim_d   = limit;
      zero_d  = (in == '0);
      stage_d = STAGE_TOP;
      ready_d = 1'b0;
    end else if (state_q == BUSY) begin
`ifdef AIRI5C_LNORM_EARLY_EXIT_EN
      if (val_q[n-1] || ({1'b0, cnt_q} == cap)) begin
        state_d = DONE;
        ready_d = 1'b1;
        out_d   = val_q;
        shamt_d = cnt_q;
      end else
`endif
      begin
        val_d = val_nx;
        cnt_d = cnt_nx;
        if (stage_q == '0) begin
          state_d = DONE;
          ready_d = 1'b1;
          out_d   = val_nx;
          shamt_d = cnt_nx;
        end else begin
          stage_d = stage_q - SW'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      val_q   <= '0;
      cnt_q   <= '0;
      lim_q   <= '0;
      stage_q <= '0;
      out_q   <= '0;
      shamt_q <= '0;
      zero_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      stage_q <= stage_d;
      out_q   <= out_d;
      shamt_q <= shamt_d;
      zero_q  <= zero_d;
      ready_q <= ready_d;
    end
  end

  assign out   = out_q;
  assign shamt = shamt_q;
  assign zero  = zero_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_airi5c_lnormalizer.sv
// ---------------------------------------------------------------------------
// tb_airi5c_lnormalizer
//
// Self-checking bench for airi5c_lnormalizer (n=24, s=5). A table of
// directed vectors with hand-computed results, followed by hand-written
// sequences for restart, kill, hold and asynchronous reset behaviour.
// ---------------------------------------------------------------------------
module tb_airi5c_lnormalizer;

  localparam int N = 24;
  localparam int S = 5;

  logic         clk = 1'b0;
  logic         n_reset;
  logic         kill;
  logic         load;
  logic [N-1:0] in;
  logic [S-1:0] limit;
  logic [N-1:0] out;
  logic [S-1:0] shamt;
  logic         zero;
  logic         ready;

  int checks = 0;
  int errors = 0;

  airi5c_lnormalizer #(.n(N), .s(S)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .kill    (kill),
    .load    (load),
    .in      (in),
    .limit   (limit),
    .out     (out),
    .shamt   (shamt),
    .zero    (zero),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] in;
    logic [S-1:0] lim;
    logic [N-1:0] out;
    logic [S-1:0] shamt;
    logic         zero;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse load for one edge; returns at the negedge after that edge.
  task automatic do_load(input logic [N-1:0] v, input logic [S-1:0] l);
    @(negedge clk);
    in    = v;
    limit = l;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Counts edges after the load edge until ready, bounded.
  task automatic wait_ready(output int lat);
    lat = 0;
    while (!ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_latency(input string name, input int lat, input logic msb_set);
`ifdef AIRI5C_LNORM_EARLY_EXIT_EN
    if (msb_set) check(name, lat, 1);
    else         check(name, (lat >= 1 && lat <= S) ? 1 : 0, 1);
`else
    check(name, lat, S);
`endif
  endtask

  vec_t vecs[10];
  int   lat;

  initial begin
    vecs[0] = '{24'h000001, 5'd31, 24'h800000, 5'd23, 1'b0};
    vecs[1] = '{24'h800000, 5'd31, 24'h800000, 5'd0,  1'b0};
    vecs[2] = '{24'h000100, 5'd4,  24'h001000, 5'd4,  1'b0};
    vecs[3] = '{24'h000000, 5'd31, 24'h000000, 5'd24, 1'b1};
    vecs[4] = '{24'h000000, 5'd7,  24'h000000, 5'd7,  1'b1};
    vecs[5] = '{24'h123456, 5'd31, 24'h91A2B0, 5'd3,  1'b0};
    vecs[6] = '{24'h0000FF, 5'd10, 24'h03FC00, 5'd10, 1'b0};
    vecs[7] = '{24'h000001, 5'd0,  24'h000001, 5'd0,  1'b0};
    vecs[8] = '{24'h000001, 5'd24, 24'h800000, 5'd23, 1'b0};
    vecs[9] = '{24'h000000, 5'd0,  24'h000000, 5'd0,  1'b1};

    n_reset = 1'b0;
    kill    = 1'b0;
    load    = 1'b0;
    in      = '0;
    limit   = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", ready, 0);
    check("reset_out",   out,   0);
    check("reset_shamt", shamt, 0);
    check("reset_zero",  zero,  0);
    n_reset = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      do_load(vecs[i].in, vecs[i].lim);
      check($sformatf("v%0d_ready_low", i), ready, 0);
      wait_ready(lat);
      check($sformatf("v%0d_ready", i), ready, 1);
      check_latency($sformatf("v%0d_latency", i), lat, vecs[i].in[N-1]);
      check($sformatf("v%0d_out", i),   out,   vecs[i].out);
      check($sformatf("v%0d_shamt", i), shamt, vecs[i].shamt);
      check($sformatf("v%0d_zero", i),  zero,  vecs[i].zero);
    end

    // Result is a held level: stays stable while idle in DONE
    repeat (3) @(negedge clk);
    check("hold_ready", ready, 1);
    check("hold_shamt", shamt, 0);
    check("hold_zero",  zero,  1);

    // Load in DONE drops ready on that edge; fresh result for 0x123456
    do_load(24'h123456, 5'd2);
    check("done_load_ready", ready, 0);
    wait_ready(lat);
    check("lim2_out",   out,   24'h48D158);
    check("lim2_shamt", shamt, 2);

    // Kill on the 2nd edge together with a load: kill wins, IDLE afterwards
    do_load(24'h000001, 5'd31);           // load on edge 1
    in   = 24'h00F000;
    load = 1'b1;
    kill = 1'b1;
    @(negedge clk);                        // edge 2
    load = 1'b0;
    kill = 1'b0;
    check("kill_ready", ready, 0);
    check("kill_out",   out,   0);
    check("kill_shamt", shamt, 0);
    check("kill_zero",  zero,  0);
    repeat (8) @(negedge clk);
    check("kill_idle_ready", ready, 0);
    check("kill_idle_out",   out,   0);
    do_load(24'h00F000, 5'd31);
    wait_ready(lat);
    check("after_kill_ready", ready, 1);
    check("after_kill_out",   out,   24'hF00000);
    check("after_kill_shamt", shamt, 8);

    // Restart while BUSY: load on edge 3 replaces the first operation
    do_load(24'h000001, 5'd31);           // edge 1
    @(negedge clk);                        // edge 2
    in   = 24'h400000;
    load = 1'b1;
    @(negedge clk);                        // edge 3
    load = 1'b0;
    check("restart_ready_low", ready, 0);
    wait_ready(lat);
    check("restart_ready", ready, 1);
    check_latency("restart_latency", lat, 1'b0);
    check("restart_out",   out,   24'h800000);
    check("restart_shamt", shamt, 1);
    @(negedge clk);
    check("restart_single_out", out, 24'h800000);

    // Asynchronous reset mid-operation clears everything at once
    do_load(24'h000001, 5'd31);
    @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    check("rst_mid_ready", ready, 0);
    check("rst_mid_out",   out,   0);
    check("rst_mid_shamt", shamt, 0);
    check("rst_mid_zero",  zero,  0);
    @(negedge clk);
    n_reset = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_idle_ready", ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
